// File: rtl/machine_run_ctrl_if.sv
// Control/result bundle between a run requester (master) and machine_run_ctrl (slave).
// Result handshake: res_valid holds with res_data/res_timeout/cycles stable until a rising edge samples res_ready=1.
interface machine_run_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic [CNT_W-1:0] budget;
    logic             abort;
    logic [12:0]      mach_result;
    logic             mach_clr;
    logic             mach_en;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [12:0]      res_data;
    logic             res_timeout;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, budget, abort, mach_result, res_ready,
        input  mach_clr, mach_en, busy, res_valid, res_data, res_timeout, cycles
    );

    modport slave (
        input  start, budget, abort, mach_result, res_ready,
        output mach_clr, mach_en, busy, res_valid, res_data, res_timeout, cycles
    );
endinterface

// File: rtl/machine_run_ctrl.sv
// Run controller for the Machine: clears it, enables it for up to budget cycles,
// and captures the result on halt or budget expiry. FSM state is exported on dbg_state.
module machine_run_ctrl #(
    parameter int          CNT_W     = 16,
    parameter logic [12:0] HALT_CODE = 13'h1FFF
) (
    input  logic                system1000,
    input  logic                system1000_rstn,
    machine_run_ctrl_if.slave   bus,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] budget_q;
    logic [CNT_W-1:0] cycles_q;
    logic [12:0]      res_data_q;
    logic             res_timeout_q;
    logic             halt;
    logic             expire;
    logic             accept;

    assign halt   = (bus.mach_result == HALT_CODE);
    // Compared before the increment, so the exit cycle is the budget_q-th RUN cycle.
    assign expire = (cycles_q == (budget_q - ONE));
    assign accept = (state_q == IDLE) && bus.start && (bus.budget != '0);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CLEAR;
            CLEAR:   state_d = bus.abort ? IDLE : RUN;
            RUN: begin
                if (bus.abort)          state_d = IDLE;
                else if (halt || expire) state_d = DONE;
            end
            DONE:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result registers are zeroed on acceptance so they already read 0 during CLEAR.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            budget_q      <= '0;
            cycles_q      <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                budget_q      <= bus.budget;
                cycles_q      <= '0;
                res_data_q    <= '0;
                res_timeout_q <= 1'b0;
            end else if ((state_q == RUN) && !bus.abort) begin
                cycles_q <= cycles_q + ONE;
                if (halt || expire) begin
                    res_data_q    <= bus.mach_result;
                    res_timeout_q <= !halt;
                end
            end
        end
    end

    always_comb begin
        bus.mach_clr    = (state_q == CLEAR);
        bus.mach_en     = (state_q == RUN);
        bus.busy        = (state_q == CLEAR) || (state_q == RUN);
        bus.res_valid   = (state_q == DONE);
        bus.res_data    = res_data_q;
        bus.res_timeout = res_timeout_q;
        bus.cycles      = cycles_q;
        dbg_state       = state_q;
    end
endmodule

// File: tb/tb_machine_run_ctrl.sv
// Randomized bench for machine_run_ctrl: a Machine model answers mach_en with
// per-run halt/abort plans, and a monitor scores results against an expected queue.
module tb_machine_run_ctrl;
  localparam int          CNT_W = 8;
  localparam logic [12:0] HALT  = 13'h1FFF;
  localparam int          W     = 13 + 1 + CNT_W;
  localparam int          NEVER = 1 << 20;

  logic       system1000 = 1'b0;
  logic       system1000_rstn = 1'b0;
  logic [1:0] dbg_state;

  machine_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  machine_run_ctrl #(.CNT_W(CNT_W), .HALT_CODE(HALT)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .bus             (bus),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 system1000 = ~system1000;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  int          cur_halt = NEVER;
  int          cur_abort = -1;
  logic [12:0] cur_fill = 13'h0;
  int          run_idx = 0;
  int          en_cnt = 0;
  int          clr_cnt = 0;
  int          block_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Machine model: drives mach_result and abort ----------------
  always @(negedge system1000) begin
    if (!system1000_rstn) begin
      run_idx = 0;
      bus.abort = 1'b0;
      bus.mach_result = 13'h0;
    end else if (bus.mach_clr) begin
      run_idx = 0;
      clr_cnt++;
      bus.abort = (cur_abort == 0);
      bus.mach_result = cur_fill;
    end else if (bus.mach_en) begin
      run_idx++;
      en_cnt++;
      bus.mach_result = (run_idx == cur_halt) ? HALT : cur_fill;
      bus.abort = (run_idx == cur_abort);
    end else begin
      bus.abort = 1'($urandom_range(0, 1));
      bus.mach_result = 13'($urandom_range(0, 8190));
    end
  end

  // ---------------- monitor: checks presented results, drives res_ready ----------------
  always @(negedge system1000) begin
    logic [W-1:0] e;
    if (!system1000_rstn) begin
      bus.res_ready = 1'b0;
    end else if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data=%0h timeout=%0b cycles=%0d expected none at %0t",
                 bus.res_data, bus.res_timeout, bus.cycles, $time);
        bus.res_ready = 1'b1;
      end else begin
        e = exp_q[0];
        check("res_data", 64'(bus.res_data), 64'(e[W-1 -: 13]));
        check("res_timeout", 64'(bus.res_timeout), 64'(e[CNT_W]));
        check("cycles", 64'(bus.cycles), 64'(e[CNT_W-1:0]));
        check("done_quiet", 64'({bus.busy, bus.mach_en, bus.mach_clr}), 64'(0));
        if (block_ready > 0) begin
          block_ready--;
          bus.res_ready = 1'b0;
        end else begin
          bus.res_ready = ($urandom_range(0, 2) == 0);
        end
        if (bus.res_ready) void'(exp_q.pop_front());
      end
    end else begin
      bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_run(input int b, input int halt_at, input int abort_at,
                        input logic [12:0] fill, input int block);
    int  m;
    bit  no_res;
    int  exp_en;
    bit  finished;
    cur_halt = halt_at;
    cur_abort = abort_at;
    cur_fill = fill;
    en_cnt = 0;
    clr_cnt = 0;
    block_ready = block;
    m = (halt_at < b) ? halt_at : b;
    no_res = (abort_at >= 0) && (abort_at <= m);
    exp_en = no_res ? abort_at : m;
    if (!no_res) begin
      if (halt_at <= b) exp_q.push_back({HALT, 1'b0, CNT_W'(halt_at)});
      else              exp_q.push_back({fill, 1'b1, CNT_W'(b)});
    end
    @(negedge system1000);
    bus.start = 1'b1;
    bus.budget = CNT_W'(b);
    @(negedge system1000);
    bus.start = 1'b0;
    bus.budget = CNT_W'($urandom);
    check("clr_latency", 64'(bus.mach_clr), 64'(1));
    finished = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge system1000);
      if (!bus.busy && !bus.res_valid) begin
        bus.start = 1'b0;
        finished = 1;
        break;
      end
      // starts and budget changes while busy or holding a result must be ignored
      bus.start = ($urandom_range(0, 3) == 0);
      bus.budget = CNT_W'($urandom);
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL run_timeout: got busy run after 2000 cycles expected idle (budget=%0d)", b);
      bus.start = 1'b0;
    end
    check("en_count", 64'(en_cnt), 64'(exp_en));
    check("clr_count", 64'(clr_cnt), 64'(1));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    if (no_res) check("abort_cycles", 64'(bus.cycles), 64'((abort_at > 0) ? abort_at - 1 : 0));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.mach_clr, bus.mach_en, bus.busy, bus.res_valid,
                     bus.res_data, bus.res_timeout, bus.cycles}), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.budget = '0;
    repeat (3) @(negedge system1000);
    check_all_zero("reset_outputs");
    system1000_rstn = 1'b1;

    // halt on 4th RUN cycle, then plain timeout with long backpressure
    do_run(10, 4, -1, 13'h0000, 0);
    do_run(5, NEVER, -1, 13'h0042, 20);
    // aborts: in RUN, in CLEAR; coincidences of halt with expiry, with and without abort
    do_run(10, NEVER, 3, 13'h0123, 0);
    do_run(6, 2, 0, 13'h0777, 0);
    do_run(3, 3, -1, 13'h0055, 0);
    do_run(3, 3, 3, 13'h0055, 0);
    // full-count budget without wrap
    do_run((1 << CNT_W) - 1, NEVER, -1, 13'h0ABC, 2);

    // zero budget start is ignored
    @(negedge system1000);
    bus.start = 1'b1;
    bus.budget = '0;
    @(negedge system1000);
    bus.start = 1'b0;
    check("zero_budget_busy", 64'({bus.busy, bus.mach_clr}), 64'(0));
    @(negedge system1000);
    check("zero_budget_clr", 64'({bus.busy, bus.mach_clr}), 64'(0));

    // asynchronous reset mid-RUN, released between edges
    cur_halt = NEVER;
    cur_abort = -1;
    cur_fill = 13'h0011;
    @(negedge system1000);
    bus.start = 1'b1;
    bus.budget = CNT_W'(40);
    @(negedge system1000);
    bus.start = 1'b0;
    repeat (6) @(negedge system1000);
    check("pre_reset_running", 64'({bus.mach_en, bus.cycles != 0}), 64'(3));
    #2 system1000_rstn = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    @(negedge system1000);
    system1000_rstn = 1'b1;
    do_run(7, 5, -1, 13'h0321, 1);

    // randomized runs
    for (int i = 0; i < 30; i++) begin
      int b, h, a;
      b = $urandom_range(1, 20);
      h = ($urandom_range(0, 2) != 0) ? int'($urandom_range(1, 25)) : NEVER;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 22)) : -1;
      do_run(b, h, a, 13'($urandom_range(0, 8190)), $urandom_range(0, 5));
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got no completion expected finish before 2000000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/machine_run_ctrl.md
MACHINE_RUN_CTRL -- requirements
Module: machine_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the budget and cycle counter.
REQ-002 Parameter HALT_CODE, default 13'h1FFF: mach_result value that signals the machine has halted.
REQ-003 system1000  in  1: the single clock; all state updates on the rising edge.
REQ-004 system1000_rstn  in  1: reset, asynchronous, active-low.
REQ-005 start  in  1: run request, sampled only in IDLE.
REQ-006 budget  in  CNT_W: maximum RUN cycles, latched on an accepted start.
REQ-007 abort  in  1: cancels the run in CLEAR or RUN.
REQ-008 mach_result  in  13: result bus from the Machine top entity.
REQ-009 mach_clr  out  1: one-cycle synchronous clear pulse to the Machine.
REQ-010 mach_en  out  1: Machine advance enable.
REQ-011 busy  out  1: high in CLEAR and RUN.
REQ-012 res_valid  out  1: result available.
REQ-013 res_ready  in  1: consumer accepts the result.
REQ-014 res_data  out  13: captured machine result.
REQ-015 res_timeout  out  1: run ended by budget expiry, not by halt.
REQ-016 cycles  out  CNT_W: number of RUN cycles executed.

Function
REQ-017 The FSM SHALL have four states: IDLE, CLEAR, RUN, DONE; all outputs are Moore decodes of registers.
REQ-018 In IDLE, start=1 with budget!=0 SHALL latch budget into budget_q and move to CLEAR; start with budget==0 SHALL be ignored.
REQ-019 CLEAR SHALL last exactly one cycle: mach_clr=1, mach_en=0, res_data/res_timeout/cycles cleared to 0; next state RUN.
REQ-020 In RUN, mach_en SHALL be 1 and cycles SHALL increment by 1 on every RUN cycle, including the exit cycle.
REQ-021 In RUN, mach_result==HALT_CODE SHALL cause a transition to DONE with res_data<=mach_result and res_timeout<=0.
REQ-022 In RUN, with no halt and cycles==budget_q-1, the block SHALL transition to DONE with res_data<=mach_result and res_timeout<=1.
REQ-023 If halt and budget expiry coincide, halt SHALL take priority, giving res_timeout=0.
REQ-024 abort=1 in CLEAR or RUN SHALL go to IDLE next cycle with no result; mach_en drops to 0; res_data, res_timeout and cycles keep their current values.
REQ-025 abort SHALL take priority over halt and expiry in the same cycle; abort SHALL be ignored in IDLE and DONE.
REQ-026 In DONE, res_valid SHALL be 1 and res_data/res_timeout/cycles SHALL be stable; res_ready=1 SHALL go to IDLE next cycle.
REQ-027 start asserted outside IDLE SHALL be ignored, not queued; budget changes after acceptance SHALL have no effect.
REQ-028 Latency: accepted start at edge k gives mach_clr high in cycle k+1 and mach_en high from k+2 for at most budget_q cycles.
REQ-029 budget=2^CNT_W-1 SHALL run the full count without counter wrap.

Reset
REQ-030 While system1000_rstn=0, regardless of clock: state=IDLE, mach_clr=0, mach_en=0, busy=0, res_valid=0, res_data=0, res_timeout=0, cycles=0, budget_q=0.
REQ-031 Reset asserted mid-RUN or in DONE SHALL discard the run and any pending result immediately.
REQ-032 The first accepted start SHALL be the one sampled on the first rising edge after reset is released.

Verification
REQ-033 Halt run: budget=10, mach_result=HALT_CODE on the 4th RUN cycle -> res_valid=1, res_data=13'h1FFF, res_timeout=0, cycles=4, 4 mach_en cycles.
REQ-034 Timeout run: budget=5, mach_result held at 13'h0042 -> exactly 5 mach_en cycles, res_data=13'h0042, res_timeout=1, cycles=5.
REQ-035 Backpressure and ignored start: res_ready=0 for 20 cycles in DONE with start pulsed -> res_valid held, outputs stable, no mach_clr; res_ready=1 -> IDLE next cycle.
REQ-036 Abort: abort on the 3rd RUN cycle -> mach_en=0 next cycle, state IDLE, res_valid never asserted; budget=0 start -> stays IDLE.
REQ-037 Coincidence: budget=3 with halt on the 3rd RUN cycle -> res_timeout=0, cycles=3; the same case plus abort -> IDLE, no result.
REQ-038 Reset mid-RUN: rstn low between clock edges -> all outputs 0 asynchronously; a fresh start after release runs normally.
